// File: rtl/vproc_resp_pkg.sv
// Shared types and constants for the VProc memory responder.
// The LFSR helpers are used only when VPROC_RESP_RAND_WAIT_EN is defined.
package vproc_resp_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        ACK  = 2'd2
    } resp_state_e;

    // Wide enough for WAIT_STATES (max 255) plus up to 3 random extra cycles.
    localparam int CNT_W = 9;

    localparam int                LFSR_W        = 16;
    // Fibonacci taps 16,14,13,11 expressed as bits 15,13,12,10.
    localparam logic [LFSR_W-1:0] LFSR_TAPS     = 16'hB400;
    localparam logic [LFSR_W-1:0] LFSR_SEED_DEF = 16'hACE1;

    function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] v);
        return {v[LFSR_W-2:0], ^(v & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/vproc_resp_lfsr.sv
// Free-running 16-bit Fibonacci LFSR; exists only under VPROC_RESP_RAND_WAIT_EN.
// Latency: advances every cycle. Backpressure: none.
// The value reloads SEED on reset.
`ifdef VPROC_RESP_RAND_WAIT_EN
module vproc_resp_lfsr
    import vproc_resp_pkg::*;
#(
    parameter logic [LFSR_W-1:0] SEED = LFSR_SEED_DEF
) (
    input  logic              Clk,
    input  logic              nReset,
    output logic [LFSR_W-1:0] value
);

    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) value <= SEED;
        else         value <= lfsr_next(value);
    end

endmodule
`endif

// File: rtl/vproc_mem_responder.sv
// VProc bus target with byte-enabled word memory; VPROC_RESP_RAND_WAIT_EN adds 0..3 random waits.
// Latency: ack visible WAIT_STATES edges after the request is first sampled; one IDLE cycle between beats.
// Backpressure: the initiator holds WE/RD until it samples the one-cycle WRAck/RDAck pulse.
module vproc_mem_responder
    import vproc_resp_pkg::*;
#(
    parameter int          MEM_AW      = 10,
    parameter int          ADDR_SHIFT  = 0,
    parameter int          WAIT_STATES = 1,
    parameter logic [15:0] LFSR_SEED   = LFSR_SEED_DEF
) (
    input  logic        Clk,
    input  logic        nReset,
    input  logic [31:0] Addr,
    input  logic [3:0]  BE,
    input  logic        WE,
    input  logic        RD,
    input  logic [31:0] WrData,
    output logic [31:0] RdData,
    output logic        WRAck,
    output logic        RDAck,
    output logic        ProtErr
);

    localparam int DEPTH = 1 << MEM_AW;

    logic [31:0]       mem [DEPTH];
    logic [MEM_AW-1:0] idx;
    logic              req_vld;
    logic [CNT_W-1:0]  ws_total;
    logic [CNT_W-1:0]  cnt_q;
    logic              op_wr_q;
    resp_state_e       state_q, state_d;
    logic              ack_go, mem_wr, load_cnt;
    logic              unused_addr;

    // High address bits alias; only the index slice selects a word.
    assign idx         = Addr[MEM_AW+ADDR_SHIFT-1:ADDR_SHIFT];
    assign unused_addr = ^Addr;
    assign req_vld     = WE ^ RD;

`ifdef VPROC_RESP_RAND_WAIT_EN
    logic [LFSR_W-1:0] lfsr_val;
    logic              unused_lfsr;

    vproc_resp_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
        .Clk    (Clk),
        .nReset (nReset),
        .value  (lfsr_val)
    );

    assign unused_lfsr = ^lfsr_val[LFSR_W-1:2];
    assign ws_total    = CNT_W'(WAIT_STATES) + CNT_W'(lfsr_val[1:0]);
`else
    assign ws_total    = CNT_W'(WAIT_STATES);
`endif

    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) state_q <= IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (req_vld) state_d = (ws_total == '0) ? ACK : WAIT;
            WAIT: begin
                if (!req_vld)                   state_d = IDLE;
                else if (cnt_q == CNT_W'(1))    state_d = ACK;
            end
            ACK:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        load_cnt = (state_q == IDLE) && req_vld;
        ack_go   = (state_d == ACK) && (state_q != ACK);
        mem_wr   = (state_q == ACK) && op_wr_q;
        WRAck    = (state_q == ACK) && op_wr_q;
        RDAck    = (state_q == ACK) && !op_wr_q;
    end

    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            cnt_q   <= '0;
            op_wr_q <= 1'b0;
            RdData  <= '0;
            ProtErr <= 1'b0;
        end else begin
            if (load_cnt)
                cnt_q <= ws_total;
            else if (state_q == WAIT && cnt_q != '0)
                cnt_q <= cnt_q - CNT_W'(1);
            // ack_go implies exactly one of WE/RD is set.
            if (ack_go) begin
                op_wr_q <= WE;
                if (!WE) RdData <= mem[idx];
            end
            ProtErr <= ProtErr | (WE & RD);
        end
    end

    // Write commits on the edge that closes the ack cycle; reset drops ACK first.
    always_ff @(posedge Clk) begin
        if (mem_wr) begin
            for (int b = 0; b < 4; b++) begin
                if (BE[b]) mem[idx][8*b +: 8] <= WrData[8*b +: 8];
            end
        end
    end

endmodule

// File: tb/tb_vproc_mem_responder.sv
// Directed bench for vproc_mem_responder: three instances with WAIT_STATES 1, 0 and 3 share one bus.
module tb_vproc_mem_responder;

    logic        Clk = 1'b0;
    logic        nReset;
    logic [31:0] Addr;
    logic [3:0]  BE;
    logic [31:0] WrData;
    logic [2:0]  we_v, rd_v, wrack_v, rdack_v, perr_v;
    logic [31:0] rdd [3];

    int n_chk = 0;
    int n_bad = 0;
    int ws_of [3] = '{1, 0, 3};
    int last_k = 0;

    always #5 Clk = ~Clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int WS = (g == 0) ? 1 : (g == 1) ? 0 : 3;
        vproc_mem_responder #(
            .MEM_AW      (10),
            .ADDR_SHIFT  (0),
            .WAIT_STATES (WS),
            .LFSR_SEED   (16'hACE1)
        ) u_dut (
            .Clk     (Clk),
            .nReset  (nReset),
            .Addr    (Addr),
            .BE      (BE),
            .WE      (we_v[g]),
            .RD      (rd_v[g]),
            .WrData  (WrData),
            .RdData  (rdd[g]),
            .WRAck   (wrack_v[g]),
            .RDAck   (rdack_v[g]),
            .ProtErr (perr_v[g])
        );
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Called on a negedge; raises one request, waits for its ack, checks it, drops the request.
    // k counts edges after the first sampling edge until the ack is visible.
    task automatic xact(input string tag, input int sel, input bit wr, input logic [31:0] a,
                        input logic [31:0] d, input logic [3:0] be, input logic [31:0] exp_rd);
        bit seen;
        int k;
        Addr = a; WrData = d; BE = be;
        we_v = '0; rd_v = '0;
        if (wr) we_v[sel] = 1'b1;
        else    rd_v[sel] = 1'b1;
        seen = 1'b0;
        k = 0;
        for (int n = 0; n < 40 && !seen; n++) begin
            @(negedge Clk);
            if (wr ? wrack_v[sel] : rdack_v[sel]) begin
                seen = 1'b1;
                k = n;
            end
        end
        chk({tag, "_ack_seen"}, 32'(seen), 1);
        if (seen) begin
`ifdef VPROC_RESP_RAND_WAIT_EN
            chk({tag, "_delay_rng"}, 32'(k >= ws_of[sel] && k <= ws_of[sel] + 3), 1);
`else
            chk({tag, "_delay"}, k, ws_of[sel]);
`endif
            last_k = k;
            chk({tag, "_other_ack"}, 32'(wr ? rdack_v[sel] : wrack_v[sel]), 0);
            if (!wr) chk({tag, "_rdata"}, rdd[sel], exp_rd);
            @(negedge Clk);
            chk({tag, "_ack_width"}, 32'(wrack_v[sel] | rdack_v[sel]), 0);
        end
        we_v = '0; rd_v = '0;
    endtask

    initial begin
        bit seen;
        nReset = 1'b0;
        Addr = '0; BE = '0; WrData = '0;
        we_v = '0; rd_v = '0;
        repeat (2) @(negedge Clk);
        chk("rst_wrack", 32'(wrack_v[0]), 0);
        chk("rst_rdack", 32'(rdack_v[0]), 0);
        chk("rst_rddata", rdd[0], 0);
        chk("rst_proterr", 32'(perr_v[0]), 0);
        chk("rst_rddata_ws3", rdd[2], 0);
        nReset = 1'b1;

        // Basic write/read, one wait state.
        xact("wr10", 0, 1, 32'h10, 32'hDEADBEEF, 4'hF, '0);
        xact("rd10", 0, 0, 32'h10, '0, '0, 32'hDEADBEEF);

        // Byte enables.
        xact("be_full", 0, 1, 32'h30, 32'h11223344, 4'hF, '0);
        xact("be_5",    0, 1, 32'h30, 32'hAABBCCDD, 4'h5, '0);
        xact("be_rd1",  0, 0, 32'h30, '0, '0, 32'h11BB33DD);
        xact("be_0",    0, 1, 32'h30, 32'h55555555, 4'h0, '0);
        xact("be_rd2",  0, 0, 32'h30, '0, '0, 32'h11BB33DD);

        // Zero-wait burst with back-to-back beats, then aliasing.
        for (int i = 0; i < 4; i++)
            xact($sformatf("bw%0d", i), 1, 1, 32'h20 + i, 32'hA0000000 + i, 4'hF, '0);
        for (int i = 0; i < 4; i++)
            xact($sformatf("br%0d", i), 1, 0, 32'h20 + i, '0, '0, 32'hA0000000 + i);
        xact("alias", 1, 0, 32'h420, '0, '0, 32'hA0000000);

        // Aborted read with three wait states, then normal traffic.
        Addr = 32'h5; rd_v[2] = 1'b1;
        @(negedge Clk);
        rd_v = '0;
        seen = 1'b0;
        repeat (6) begin @(negedge Clk); seen |= rdack_v[2]; end
        chk("abort_rd_noack", 32'(seen), 0);
        xact("ws3_wr", 2, 1, 32'h5, 32'h0BADF00D, 4'hF, '0);
        xact("ws3_rd", 2, 0, 32'h5, '0, '0, 32'h0BADF00D);

        // Aborted write must not touch memory.
        Addr = 32'h5; WrData = 32'hFFFFFFFF; BE = 4'hF; we_v[2] = 1'b1;
        repeat (2) @(negedge Clk);
        we_v = '0;
        seen = 1'b0;
        repeat (6) begin @(negedge Clk); seen |= wrack_v[2]; end
        chk("abort_wr_noack", 32'(seen), 0);
        xact("abort_wr_rd", 2, 0, 32'h5, '0, '0, 32'h0BADF00D);

        // Protocol error: WE and RD together.
        Addr = 32'h10; WrData = '0; BE = 4'hF; we_v[0] = 1'b1; rd_v[0] = 1'b1;
        @(negedge Clk);
        chk("perr_set", 32'(perr_v[0]), 1);
        we_v = '0; rd_v = '0;
        seen = 1'b0;
        repeat (4) begin @(negedge Clk); seen |= wrack_v[0] | rdack_v[0]; end
        chk("perr_noack", 32'(seen), 0);
        chk("perr_sticky", 32'(perr_v[0]), 1);
        xact("perr_mem", 0, 0, 32'h10, '0, '0, 32'hDEADBEEF);
        nReset = 1'b0;
        #1;
        chk("perr_clr", 32'(perr_v[0]), 0);
        @(negedge Clk);
        nReset = 1'b1;

        // Reset while the write ack is up: ack drops, write is lost.
        Addr = 32'h5; WrData = 32'hCAFECAFE; BE = 4'hF; we_v[2] = 1'b1;
        seen = 1'b0;
        for (int n = 0; n < 20 && !seen; n++) begin
            @(negedge Clk);
            seen = wrack_v[2];
        end
        chk("rst_ack_reached", 32'(seen), 1);
        nReset = 1'b0;
        #1;
        chk("rst_ack_drop", 32'(wrack_v[2]), 0);
        we_v = '0;
        @(negedge Clk);
        nReset = 1'b1;
        xact("rst_wr_lost", 2, 0, 32'h5, '0, '0, 32'h0BADF00D);

`ifdef VPROC_RESP_RAND_WAIT_EN
        begin
            logic [7:0] mask;
            mask = '0;
            for (int i = 0; i < 100; i++) begin
                xact("rand", 0, 0, 32'h10, '0, '0, 32'hDEADBEEF);
                mask[last_k[2:0]] = 1'b1;
            end
            chk("rand_distinct", 32'($countones(mask) >= 2), 1);
        end
`endif

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
